// File: rtl/led_bank_issuer_pkg.sv
// Shared LedBank instruction definitions: opcodes, instruction width, field layout.
package LedBankDefs;
  localparam int INST_W  = 12;
  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 8;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD0 = 4'h2;

  typedef logic [INST_W-1:0] inst_t;

  // LDn opcodes are contiguous starting at LD0, so n maps to LD0+n.
  function automatic logic [3:0] op_ldn(input logic [2:0] n);
    return OP_LD0 + {1'b0, n};
  endfunction

  function automatic inst_t mk_inst(input logic [3:0] op, input logic [OPC_LSB-1:0] imm);
    inst_t r;
    r = '0;
    r[OPC_MSB:OPC_LSB] = op;
    r[OPC_LSB-1:0]     = imm;
    return r;
  endfunction
endpackage

// File: rtl/led_bank_bit_diff.sv
// Classifies the XOR between target and shadow: no change, one bit, or more.
module led_bank_bit_diff (
  input  logic [7:0] diff_i,
  output logic       zero_o,
  output logic       single_o,
  output logic [2:0] idx_o
);
  always_comb begin
    zero_o   = (diff_i == 8'h00);
    single_o = !zero_o && ((diff_i & (diff_i - 8'd1)) == 8'h00);
    idx_o    = 3'd0;
    for (int i = 0; i < 8; i++)
      if (diff_i[i]) idx_o = 3'(i);
  end
endmodule

// File: rtl/led_bank_issuer.sv
// Turns whole LED target patterns into the cheapest LedBank instruction
// (none, LDn or LDI), tracking the resulting LED state in a shadow register.
module led_bank_issuer
  import LedBankDefs::*;
#(
  parameter int GapCycles = 0,
  parameter int CntWidth  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        req_pattern,
  input  logic              req_force,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [INST_W-1:0] inst,
  output logic              inst_en,
  output logic [7:0]        shadow,
  output logic              busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]          state_q, state_d;
  inst_t               inst_q, inst_d;
  logic                inst_en_q, inst_en_d;
  logic [7:0]          shadow_q, shadow_d;
  logic [7:0]          pend_q, pend_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic       d_zero, d_single;
  logic [2:0] d_idx;

  led_bank_bit_diff u_diff (
    .diff_i  (req_pattern ^ shadow_q),
    .zero_o  (d_zero),
    .single_o(d_single),
    .idx_o   (d_idx)
  );

  always_comb begin
    state_d   = state_q;
    inst_d    = mk_inst(OP_NOP, 8'h00);
    inst_en_d = 1'b0;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !(d_zero && !req_force)) begin
          pend_d    = req_pattern;
          inst_en_d = 1'b1;
          state_d   = S_ISSUE;
          if (d_single && !req_force)
            inst_d = mk_inst(op_ldn(d_idx), {7'b0, req_pattern[d_idx]});
          else
            inst_d = mk_inst(OP_LDI, req_pattern);
        end
      end
      S_ISSUE: begin
        shadow_d = pend_q;
        if (GapCycles == 0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CntWidth'(GapCycles);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // Leaving on count 1 yields exactly GapCycles idle cycles.
        if (cnt_q <= CntWidth'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      inst_q    <= mk_inst(OP_NOP, 8'h00);
      inst_en_q <= 1'b0;
      shadow_q  <= 8'h00;
      pend_q    <= 8'h00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      inst_en_q <= inst_en_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign inst      = inst_q;
  assign inst_en   = inst_en_q;
  assign shadow    = shadow_q;
endmodule
